mux_nto1_pipe: RTL and testbench
================================

# mux_nto1_pipe

Parametrised N-to-1, WIDTH-bit selector with a registered, flow-controlled output stage. It generalises the datapath select muxes (register-destination, ALU-source, write-back source) to any width and input count. It adds a 2-entry elastic buffer so the select result can cross a pipeline-stage boundary under valid/ready backpressure. It is intended for the pipelined CPU datapath between decode/execute and execute/write-back.

## Interface
- WIDTH, 5, bit width of each data input and of out_data
- NUM_IN, 4, number of data inputs (≥2; need not be a power of two)
- SEL_W, $clog2(NUM_IN), select width (derived; not to be overridden)
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_data  input  NUM_IN*WIDTH  packed inputs; input i at [i*WIDTH +: WIDTH]
- sel  input  SEL_W  input index, sampled with in_valid
- in_valid  input  1  upstream offers in_data/sel
- in_ready  output  1  block can accept this cycle
- out_data  output  WIDTH  selected word at head of buffer
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts out_data
- sel_err  output  1  sticky out-of-range select flag (see Configuration)
- occupancy  output  2  entries held (0..2)

## Operation
- Push: in_valid && in_ready at a rising edge stores in_data[sel*WIDTH +: WIDTH] at buffer tail. Selection is evaluated at the push edge only; later changes to in_data/sel do not affect stored entries.
- Pop: out_valid && out_ready at a rising edge removes the head entry.
- Buffer is a 2-entry FIFO (head/tail pointers, 1-bit each, wrap 1→0), strictly in order.
- in_ready = (occupancy != 2) && !reset. It is combinational from registered state only; it never depends on out_ready.
- out_valid = (occupancy != 0). out_data = head entry, driven from a register, and is stable while out_valid && !out_ready.
- Occupancy states: EMPTY(0), ONE(1), FULL(2).
  - EMPTY: push→ONE.
  - ONE: push only→FULL; pop only→EMPTY; push+pop→ONE (head advances, new word becomes head next cycle).
  - FULL: push impossible (in_ready=0); pop→ONE.
- Contents of vacated entries are don't-care. out_data is held at its last value when EMPTY.
- Reset (at any time, including mid-transfer): occupancy=0, pointers=0, both entries=0, out_data=0, out_valid=0, sel_err=0. in_ready=0 while reset is high and 1 on the first cycle after release. In-flight data is discarded.

## Timing
- Latency: a word pushed at edge N is on out_data with out_valid=1 in the cycle after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle sustained while out_ready=1. With out_ready=0, two words are absorbed before in_ready falls.
- After a pop from FULL at edge N, in_ready=1 in the cycle after edge N.
- No combinational path from in_* to out_* or from out_ready to in_ready.

## Configuration
- MUX_NTO1_PIPE_RANGE_CHECK_EN defined:
  - A push with sel ≥ NUM_IN stores all-zero data and sets sel_err=1 at that edge.
  - sel_err stays set until reset.
  - In-range pushes are unaffected.
- Not defined:
  - Out-of-range sel stores input 0 (sel is treated as 0).
  - sel_err is tied to 0.
- The macro has no effect when NUM_IN is a power of two, except that sel_err remains 0.

## Test plan
- Reset/basic: WIDTH=5, NUM_IN=4. Hold reset, then release. Check out_valid=0, out_data=0, occupancy=0, in_ready=1. Push in_data={5'd3,5'd2,5'd1,5'd0 + 5'd9}, sel=2 → next cycle out_data=5'd2, out_valid=1.
- Streaming: out_ready=1; push sel=0,1,2,3 on consecutive cycles with distinct words. Outputs must appear in order, one per cycle, at 1-cycle latency, with in_ready never dropping.
- Backpressure: out_ready=0; push A then B → occupancy=2 and in_ready=0. A third offered word C is not taken. Raise out_ready → A, B, C delivered in order, and out_data holds A while stalled.
- Simultaneous push+pop at ONE: occupancy stays 1 and the sequence is preserved.
- Range check: NUM_IN=3, sel=3.
  - With macro: stored word=0 and sel_err=1, which persists.
  - Without macro: stored word=input 0 and sel_err=0.
- Reset mid-operation: assert reset asynchronously (between edges) with occupancy=2. Outputs must clear immediately. After release the FIFO must be empty, and the next push must be delivered correctly.

Source files
------------

// File: rtl/mux_nto1_pipe_if.sv
// Handshake/data bundle for mux_nto1_pipe: upstream select port, downstream valid/ready port, status.
// The slave modport is the block's view; master is the driver's view.
interface mux_nto1_pipe_if #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
    logic [1:0]              occupancy;

    modport master (
        output in_data, sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sel_err, occupancy
    );

    modport slave (
        input  in_data, sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, sel_err, occupancy
    );
endinterface

// File: rtl/mux_nto1_pipe.sv
// N-to-1 WIDTH-bit selector feeding a 2-entry elastic buffer with a registered head output.
// Optional macro MUX_NTO1_PIPE_RANGE_CHECK_EN: out-of-range sel stores zero and sets sticky sel_err.
module mux_nto1_pipe #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4
) (
    input  logic              clk,
    input  logic              reset,
    mux_nto1_pipe_if.slave    bus
);
    localparam int SEL_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int NUM_PAD = 1 << SEL_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    // Table padded to a power of two so every sel code indexes a defined word.
    logic [WIDTH-1:0] word_arr [NUM_PAD];

    generate
        for (genvar gi = 0; gi < NUM_PAD; gi++) begin : g_word
            if (gi < NUM_IN) begin : g_real
                assign word_arr[gi] = bus.in_data[gi*WIDTH +: WIDTH];
            end else begin : g_pad
`ifdef MUX_NTO1_PIPE_RANGE_CHECK_EN
                assign word_arr[gi] = '0;
`else
                assign word_arr[gi] = bus.in_data[WIDTH-1:0];
`endif
            end
        end
    endgenerate

    occ_e             occ_q, occ_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             push;
    logic             pop;

    assign bus.in_ready  = (occ_q != FULL) && !reset;
    assign bus.out_valid = (occ_q != EMPTY);
    assign bus.out_data  = out_data_q;
    assign bus.occupancy = occ_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_ready && (occ_q != EMPTY);

    always_comb begin
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        mem_d      = mem_q;
        out_data_d = out_data_q;

        if (push) begin
            mem_d[tail_q] = word_arr[bus.sel];
            tail_d        = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end

        case (occ_q)
            EMPTY: begin
                if (push) occ_d = ONE;
            end
            ONE: begin
                if (push && !pop)      occ_d = FULL;
                else if (pop && !push) occ_d = EMPTY;
            end
            FULL: begin
                if (pop) occ_d = ONE;
            end
            default: occ_d = EMPTY;
        endcase

        // Output register tracks the next head; it holds its last word when the buffer drains.
        if (occ_d != EMPTY) begin
            out_data_d = mem_d[head_d];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q      <= EMPTY;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            out_data_q <= '0;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            mem_q      <= mem_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef MUX_NTO1_PIPE_RANGE_CHECK_EN
    logic sel_oor;
    logic sel_err_q, sel_err_d;

    generate
        if (NUM_PAD == NUM_IN) begin : g_oor_none
            assign sel_oor = 1'b0;
        end else begin : g_oor_cmp
            assign sel_oor = ({1'b0, bus.sel} >= (SEL_W+1)'(NUM_IN));
        end
    endgenerate

    always_comb begin
        sel_err_d = sel_err_q | (push & sel_oor);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sel_err_q <= 1'b0;
        else       sel_err_q <= sel_err_d;
    end

    assign bus.sel_err = sel_err_q;
`else
    assign bus.sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed self-checking bench for mux_nto1_pipe: a 4-input instance for flow control
// and a 3-input instance for out-of-range select behaviour.
module tb_mux_nto1_pipe;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

`ifdef MUX_NTO1_PIPE_RANGE_CHECK_EN
    localparam logic [4:0] OOR_WORD = 5'd0;
    localparam logic       OOR_ERR  = 1'b1;
`else
    localparam logic [4:0] OOR_WORD = 5'd4;
    localparam logic       OOR_ERR  = 1'b0;
`endif

    mux_nto1_pipe_if #(.WIDTH(5), .NUM_IN(4)) if4 ();
    mux_nto1_pipe_if #(.WIDTH(5), .NUM_IN(3)) if3 ();

    mux_nto1_pipe #(.WIDTH(5), .NUM_IN(4)) u4 (.clk(clk), .reset(reset), .bus(if4));
    mux_nto1_pipe #(.WIDTH(5), .NUM_IN(3)) u3 (.clk(clk), .reset(reset), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        if4.in_data = '0; if4.sel = '0; if4.in_valid = 1'b0; if4.out_ready = 1'b0;
        if3.in_data = '0; if3.sel = '0; if3.in_valid = 1'b0; if3.out_ready = 1'b0;

        // Reset and release
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(if4.in_ready), 0);
        chk("rst_occ", 32'(if4.occupancy), 0);
        reset = 1'b0;
        #1;
        chk("rel_in_ready", 32'(if4.in_ready), 1);
        chk("rel_out_valid", 32'(if4.out_valid), 0);
        chk("rel_out_data", 32'(if4.out_data), 0);
        chk("rel_occ", 32'(if4.occupancy), 0);

        // Basic push, sel=2
        if4.in_data  = {5'd3, 5'd2, 5'd1, 5'd9};
        if4.sel      = 2'd2;
        if4.in_valid = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        chk("basic_data", 32'(if4.out_data), 2);
        chk("basic_valid", 32'(if4.out_valid), 1);
        chk("basic_occ", 32'(if4.occupancy), 1);
        if4.out_ready = 1'b1;
        @(negedge clk);
        chk("basic_pop_occ", 32'(if4.occupancy), 0);
        chk("basic_pop_valid", 32'(if4.out_valid), 0);
        chk("basic_hold_data", 32'(if4.out_data), 2);

        // Streaming with out_ready=1: push+pop each cycle at ONE
        if4.in_data = {5'd13, 5'd12, 5'd11, 5'd10};
        for (int i = 0; i < 4; i++) begin
            if4.sel      = 2'(i);
            if4.in_valid = 1'b1;
            @(negedge clk);
            chk("stream_data", 32'(if4.out_data), 32'(10 + i));
            chk("stream_valid", 32'(if4.out_valid), 1);
            chk("stream_in_ready", 32'(if4.in_ready), 1);
            chk("stream_occ", 32'(if4.occupancy), 1);
        end
        if4.in_valid = 1'b0;
        @(negedge clk);
        chk("stream_drain_occ", 32'(if4.occupancy), 0);

        // Backpressure: A, B absorbed, C refused until space frees
        if4.out_ready = 1'b0;
        if4.in_data   = {5'd0, 5'd0, 5'd7, 5'd0};
        if4.sel       = 2'd1;
        if4.in_valid  = 1'b1;
        @(negedge clk);
        chk("bp_a_data", 32'(if4.out_data), 7);
        chk("bp_a_occ", 32'(if4.occupancy), 1);
        chk("bp_a_in_ready", 32'(if4.in_ready), 1);
        if4.in_data = {5'd25, 15'd0};
        if4.sel     = 2'd3;
        @(negedge clk);
        chk("bp_full_occ", 32'(if4.occupancy), 2);
        chk("bp_full_in_ready", 32'(if4.in_ready), 0);
        chk("bp_hold_a", 32'(if4.out_data), 7);
        if4.in_data = {15'd0, 5'd17};
        if4.sel     = 2'd0;
        @(negedge clk);
        chk("bp_c_refused_occ", 32'(if4.occupancy), 2);
        chk("bp_c_hold_a", 32'(if4.out_data), 7);
        chk("bp_c_in_ready", 32'(if4.in_ready), 0);
        if4.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_b_data", 32'(if4.out_data), 25);
        chk("bp_b_occ", 32'(if4.occupancy), 1);
        chk("bp_b_in_ready", 32'(if4.in_ready), 1);
        @(negedge clk);
        if4.in_valid = 1'b0;
        chk("bp_c_data", 32'(if4.out_data), 17);
        chk("bp_c_occ", 32'(if4.occupancy), 1);
        @(negedge clk);
        chk("bp_drain_occ", 32'(if4.occupancy), 0);

        // Range check on the 3-input instance
        if3.out_ready = 1'b1;
        if3.in_data   = {5'd6, 5'd5, 5'd4};
        if3.sel       = 2'd2;
        if3.in_valid  = 1'b1;
        @(negedge clk);
        chk("rc_in_data", 32'(if3.out_data), 6);
        chk("rc_in_err", 32'(if3.sel_err), 0);
        if3.sel = 2'd3;
        @(negedge clk);
        chk("rc_oor_data", 32'(if3.out_data), 32'(OOR_WORD));
        chk("rc_oor_err", 32'(if3.sel_err), 32'(OOR_ERR));
        if3.sel = 2'd1;
        @(negedge clk);
        if3.in_valid = 1'b0;
        chk("rc_after_data", 32'(if3.out_data), 5);
        chk("rc_sticky_err", 32'(if3.sel_err), 32'(OOR_ERR));
        chk("rc_pow2_err", 32'(if4.sel_err), 0);

        // Asynchronous reset with the buffer full
        if4.out_ready = 1'b0;
        if4.in_data   = {5'd0, 5'd19, 5'd22, 5'd21};
        if4.sel       = 2'd0;
        if4.in_valid  = 1'b1;
        @(negedge clk);
        if4.sel = 2'd1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        chk("mr_full_occ", 32'(if4.occupancy), 2);
        #2 reset = 1'b1;
        #1;
        chk("mr_occ", 32'(if4.occupancy), 0);
        chk("mr_valid", 32'(if4.out_valid), 0);
        chk("mr_data", 32'(if4.out_data), 0);
        chk("mr_in_ready", 32'(if4.in_ready), 0);
        chk("mr_sel_err", 32'(if3.sel_err), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr_rel_occ", 32'(if4.occupancy), 0);
        chk("mr_rel_in_ready", 32'(if4.in_ready), 1);
        chk("mr_rel_valid", 32'(if4.out_valid), 0);
        if4.sel       = 2'd2;
        if4.in_valid  = 1'b1;
        if4.out_ready = 1'b1;
        @(negedge clk);
        if4.in_valid = 1'b0;
        chk("mr_push_data", 32'(if4.out_data), 19);
        chk("mr_push_valid", 32'(if4.out_valid), 1);
        @(negedge clk);
        chk("mr_push_drain", 32'(if4.occupancy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
